qdr_traffic_checker: RTL
========================

# qdr_traffic_checker

User-side traffic generator and checker for the QDR controller. It drives the controller's user strobe/address/write-data port and consumes its read-data/valid port, so it acts as the initiator end of that interface. It writes a deterministic pattern over an address range, reads the range back, and compares every returned word. Results are exposed as status registers for the ROACH2 board-test software.

## Interface
- `DATA_WIDTH`, 36: QDR data width; user words are 2*DATA_WIDTH bits.
- `ADDR_WIDTH`, 21: QDR address width.
- `DRAIN_CYCLES`, 16: idle cycles between the last write and the first read.
- `TIMEOUT_CYCLES`, 64: cycles with reads outstanding and no `usr_rd_dvld` before the run aborts.
- `clk0` in 1: user-interface clock, same as the controller's `clk0`.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse that launches a run.
- `addr_first` in ADDR_WIDTH: first address of the sweep, latched on `start`.
- `addr_last` in ADDR_WIDTH: last address (inclusive), latched on `start`.
- `seed` in 31: PRBS seed; used only when `QDR_TRAFFIC_PRBS_EN` is defined.
- `phy_rdy` in 1: controller calibrated and ready.
- `usr_wr_strb`, `usr_rd_strb` out 1: write/read request strobes.
- `usr_addr` out ADDR_WIDTH: request address.
- `usr_wr_data` out 2*DATA_WIDTH: write word.
- `usr_rd_data` in 2*DATA_WIDTH: returned read word.
- `usr_rd_dvld` in 1: `usr_rd_data` valid.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held until the next accepted `start` or `reset`.
- `pass` out 1: meaningful only while `done`=1; 1 means zero errors and no timeout.
- `timeout` out 1: run aborted on the read timeout.
- `err_cnt` out 32: mismatched words, saturating at 32'hFFFFFFFF.
- `first_err_addr` out ADDR_WIDTH: address of the first mismatch.

## Operation
- States: IDLE, WRITE, DRAIN, READ, CHECK, DONE.
- Reset forces IDLE and clears every output to 0.
- **IDLE/DONE → WRITE** on `start`.
  - Latches the range and seed.
  - Clears `err_cnt`, `first_err_addr`, `timeout`, `done` and `pass`.
  - Sets `busy`.
- `start` is ignored in all other states.
- **Sweep length:** N = ((addr_last - addr_first) mod 2^ADDR_WIDTH) + 1.
  - `addr_last` < `addr_first` wraps through the top of the address space.
  - Equal values give one word.
- **WRITE:** in each cycle with `phy_rdy`=1, assert `usr_wr_strb` with the current address and pattern word, then increment the address (mod 2^ADDR_WIDTH).
  - With `phy_rdy`=0, no strobe and no advance (stall).
  - After the Nth write, go to DRAIN.
- **DRAIN:** count DRAIN_CYCLES, then go to READ with the address reloaded to `addr_first`.
- **READ:** issue `usr_rd_strb` with the same stall rule; after N reads, go to CHECK.
- **Checker (runs during READ and CHECK):**
  - On each `usr_rd_dvld`, compare `usr_rd_data` with the expected generator, then advance the generator and the expected address.
  - On a mismatch, increment `err_cnt` (saturating).
  - On the first mismatch only, capture the expected address into `first_err_addr`.
  - A `usr_rd_dvld` that arrives in WRITE/DRAIN/IDLE/DONE is ignored.
- **CHECK → DONE** when N words have been returned.
  - On entering DONE: `busy`=0, `done`=1, `pass`=(err_cnt==0).
- **Timeout:** with reads outstanding, if TIMEOUT_CYCLES consecutive cycles pass without `usr_rd_dvld`, go to DONE with `timeout`=1 and `pass`=0.
  - The counter resets on every `usr_rd_dvld`.
- **Pattern generator:** writes and the checker each own an independent generator, both reset at the start of the run, so the check does not depend on read latency.

## Timing
- All outputs are registered.
- `start` sampled high at edge k:
  - `busy`=1 after edge k.
  - First `usr_wr_strb` is driven after edge k+1 if `phy_rdy`=1.
- Strobes are back-to-back: one request per cycle, N cycles per phase with no stalls.
- The first `usr_rd_strb` comes exactly DRAIN_CYCLES+1 cycles after the last `usr_wr_strb`.
- `done` and `pass` assert the cycle after the Nth `usr_rd_dvld` is sampled.
- Controller read latency is 11 cycles, so an unstalled run lasts about 2N+DRAIN_CYCLES+13 cycles.

## Configuration
- **`QDR_TRAFFIC_PRBS_EN` defined:** the word is a PRBS31 state S replicated and truncated to 2*DATA_WIDTH bits.
  - S starts at `seed`; a zero seed is replaced by 31'h1.
  - S advances one step per word: S ← {S[29:0], S[30]^S[27]}.
- **Not defined:** word = {~A, A}, where A is the address zero-extended to DATA_WIDTH bits (low half = address, high half = its inverse). `seed` is unused.

## Test plan
- **Clean sweep:** behavioural QDR model, `addr_first`=0, `addr_last`=15 → 16 write and 16 read strobes, `done`=1, `pass`=1, `err_cnt`=0.
- **Wrap-around:** `addr_first`=21'h1FFFFE, `addr_last`=21'h000001 → 4 words at addresses 1FFFFE, 1FFFFF, 0, 1; `pass`=1.
- **Corruption:** model flips bit 0 of the word at address 5 and at address 9 → `err_cnt`=2, `first_err_addr`=5, `pass`=0.
- **Stall and ignore:** `phy_rdy` low for 10 cycles mid-WRITE → no strobes during the stall and the sweep resumes at the next address. A second `start` while `busy`=1 is ignored.
- **Timeout:** model drops the last 3 read responses → `timeout`=1, `pass`=0, `err_cnt`=0, `done`=1 after 64 idle cycles.
- **Reset mid-run:** `reset` asserted during READ → all outputs 0 and state IDLE the next cycle; a following `start` runs cleanly.

Source files
------------

// File: rtl/qdr_traffic_checker.sv
// qdr_traffic_checker
// Initiator-side traffic generator and checker for the QDR controller user port.
// A run writes a deterministic pattern over [addr_first..addr_last] (wrapping
// through the top of the address space), waits DRAIN_CYCLES, reads the range
// back and compares every returned word against an independent generator.
//
// Optional feature macro: QDR_TRAFFIC_PRBS_EN
//   defined   : word = PRBS31 state (seeded from `seed`, zero -> 1) replicated
//               and truncated to 2*DATA_WIDTH bits, one step per word
//   undefined : word = {~A, A}, A = address zero-extended to DATA_WIDTH
//
// Ports
//   clk0, reset                 user clock, synchronous active-high reset
//   start                       one-cycle run launch (accepted in IDLE/DONE)
//   addr_first, addr_last       inclusive sweep range, latched on start
//   seed                        PRBS seed (PRBS build only)
//   phy_rdy                     controller ready; low stalls request issue
//   usr_wr_strb/usr_rd_strb     request strobes, usr_addr request address
//   usr_wr_data                 write word
//   usr_rd_data, usr_rd_dvld    returned read word and its valid
//   busy, done, pass, timeout   run status
//   err_cnt                     saturating mismatch count
//   first_err_addr              address of the first mismatching word
//
// States
//   IDLE  | waiting for start after reset
//   WRITE | issuing one write per phy_rdy cycle
//   DRAIN | idle gap between the last write and the first read
//   READ  | issuing reads; checker active
//   CHECK | all reads issued; waiting for the remaining responses
//   DONE  | results held until the next start
module qdr_traffic_checker #(
  parameter int DATA_WIDTH     = 36,
  parameter int ADDR_WIDTH     = 21,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk0,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   addr_first,
  input  logic [ADDR_WIDTH-1:0]   addr_last,
  input  logic [30:0]             seed,
  input  logic                    phy_rdy,
  output logic                    usr_wr_strb,
  output logic                    usr_rd_strb,
  output logic [ADDR_WIDTH-1:0]   usr_addr,
  output logic [2*DATA_WIDTH-1:0] usr_wr_data,
  input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
  input  logic                    usr_rd_dvld,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [31:0]             err_cnt,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam int WW  = 2 * DATA_WIDTH;
  localparam int CW  = ADDR_WIDTH + 1;
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DRAIN, S_READ, S_CHECK, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] a_first, addr_q, chk_addr, span;
  logic [CW-1:0]         n_words, req_left, rsp_left;
  logic [DCW-1:0]        drain_cnt;
  logic [TCW-1:0]        tmo_cnt;
  logic [WW-1:0]         wr_word, chk_word;
  logic accept, issue, last_req, chk_en, rsp, mismatch, last_rsp, outstanding, tmo_fire;

  // Range is inclusive and wraps, so equal endpoints mean one word.
  assign span    = addr_last - addr_first;
  assign n_words = {1'b0, span} + CW'(1);

`ifdef QDR_TRAFFIC_PRBS_EN
  localparam int REP = (WW + 30) / 31;
  logic [30:0]       wr_prbs, chk_prbs, seed_init;
  logic [31*REP-1:0] wr_rep, chk_rep;

  function automatic logic [30:0] prbs_step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  assign seed_init = (seed == '0) ? 31'h1 : seed;
  assign wr_rep    = {REP{wr_prbs}};
  assign chk_rep   = {REP{chk_prbs}};
  assign wr_word   = wr_rep[WW-1:0];
  assign chk_word  = chk_rep[WW-1:0];
`else
  logic [DATA_WIDTH-1:0] wr_a, chk_a;
  logic                  unused_seed;
  assign unused_seed = ^seed;
  assign wr_a        = DATA_WIDTH'(addr_q);
  assign chk_a       = DATA_WIDTH'(chk_addr);
  assign wr_word     = {~wr_a, wr_a};
  assign chk_word    = {~chk_a, chk_a};
`endif

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign issue    = phy_rdy && (state == S_WRITE || state == S_READ);
  assign last_req = issue && (req_left == CW'(1));
  assign chk_en   = (state == S_READ || state == S_CHECK);
  assign rsp      = chk_en && usr_rd_dvld && (rsp_left != '0);
  assign mismatch = rsp && (usr_rd_data != chk_word);
  assign last_rsp = rsp && (rsp_left == CW'(1));
  // Both counters start at N in READ; they differ exactly while reads are in flight.
  assign outstanding = chk_en && (rsp_left != req_left);
  assign tmo_fire    = outstanding && !usr_rd_dvld && (tmo_cnt == '0);

  always_ff @(posedge clk0) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WRITE;
      S_WRITE: if (last_req) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nxt = S_READ;
      S_READ: begin
        if (tmo_fire)      state_nxt = S_DONE;
        else if (last_req) state_nxt = S_CHECK;
      end
      S_CHECK: if (tmo_fire || last_rsp) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_WRITE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      usr_wr_strb    <= 1'b0;
      usr_rd_strb    <= 1'b0;
      usr_addr       <= '0;
      usr_wr_data    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      a_first        <= '0;
      addr_q         <= '0;
      chk_addr       <= '0;
      req_left       <= '0;
      rsp_left       <= '0;
      drain_cnt      <= '0;
      tmo_cnt        <= '0;
`ifdef QDR_TRAFFIC_PRBS_EN
      wr_prbs        <= '0;
      chk_prbs       <= '0;
`endif
    end else begin
      usr_wr_strb <= 1'b0;
      usr_rd_strb <= 1'b0;

      if (accept) begin
        a_first        <= addr_first;
        addr_q         <= addr_first;
        chk_addr       <= addr_first;
        req_left       <= n_words;
        rsp_left       <= n_words;
        drain_cnt      <= DCW'(DRAIN_CYCLES - 1);
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
`ifdef QDR_TRAFFIC_PRBS_EN
        wr_prbs        <= seed_init;
        chk_prbs       <= seed_init;
`endif
      end

      if (issue) begin
        usr_wr_strb <= (state == S_WRITE);
        usr_rd_strb <= (state == S_READ);
        usr_addr    <= addr_q;
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        req_left    <= req_left - CW'(1);
        if (state == S_WRITE) begin
          usr_wr_data <= wr_word;
`ifdef QDR_TRAFFIC_PRBS_EN
          wr_prbs     <= prbs_step(wr_prbs);
`endif
        end
      end

      // rsp_left still holds N here, so it doubles as the read-phase reload.
      if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt - DCW'(1);
        if (drain_cnt == '0) begin
          addr_q   <= a_first;
          req_left <= rsp_left;
        end
      end

      if (rsp) begin
        chk_addr <= chk_addr + ADDR_WIDTH'(1);
        rsp_left <= rsp_left - CW'(1);
`ifdef QDR_TRAFFIC_PRBS_EN
        chk_prbs <= prbs_step(chk_prbs);
`endif
        if (mismatch) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
          if (err_cnt == '0) first_err_addr <= chk_addr;
        end
      end

      if (!outstanding || usr_rd_dvld) tmo_cnt <= TCW'(TIMEOUT_CYCLES - 1);
      else if (tmo_cnt != '0)          tmo_cnt <= tmo_cnt - TCW'(1);

      if (state != S_DONE && state_nxt == S_DONE) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= tmo_fire;
        pass    <= !tmo_fire && !mismatch && (err_cnt == '0);
      end
    end
  end

endmodule
